// File: rtl/dma_mc_engine.sv
// Multi-channel word-copy DMA over one AXI-Lite master.
// Channels are served round-robin, one word per grant.
module dma_mc_engine #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_CH-1:0]            ch_start,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_src_addr,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_dst_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]  ch_len,
  output logic [NUM_CH-1:0]            ch_busy,
  output logic [NUM_CH-1:0]            ch_done,
  output logic [NUM_CH-1:0]            ch_err,
  output logic [ADDR_WIDTH-1:0]        m_awaddr,
  output logic                         m_awvalid,
  input  logic                         m_awready,
  output logic [DATA_WIDTH-1:0]        m_wdata,
  output logic [DATA_WIDTH/8-1:0]      m_wstrb,
  output logic                         m_wvalid,
  input  logic                         m_wready,
  input  logic [1:0]                   m_bresp,
  input  logic                         m_bvalid,
  output logic                         m_bready,
  output logic [ADDR_WIDTH-1:0]        m_araddr,
  output logic                         m_arvalid,
  input  logic                         m_arready,
  input  logic [DATA_WIDTH-1:0]        m_rdata,
  input  logic [1:0]                   m_rresp,
  input  logic                         m_rvalid,
  output logic                         m_rready
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_D, WR, WR_B
  } state_t;

  state_t                state;
  logic [CW-1:0]         rr;
  logic [CW-1:0]         g;
  logic [NUM_CH-1:0]     busy_q;
  logic [NUM_CH-1:0]     done_q;
  logic [NUM_CH-1:0]     err_q;
  logic [ADDR_WIDTH-1:0] src_q [NUM_CH];
  logic [ADDR_WIDTH-1:0] dst_q [NUM_CH];
  logic [LEN_WIDTH-1:0]  rem_q [NUM_CH];

  logic [CW-1:0] nxt;
  logic [CW-1:0] idx;
  logic          has_req;
  logic          aw_fin;
  logic          w_fin;

  assign ch_busy = busy_q;
  assign ch_done = done_q;
  assign ch_err  = err_q;

  // first busy channel after the last grant
  always_comb begin
    nxt     = rr;
    idx     = '0;
    has_req = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CW'((int'(rr) + k) % NUM_CH);
      if (!has_req && busy_q[idx]) begin
        nxt     = idx;
        has_req = 1'b1;
      end
    end
  end

  assign aw_fin = !m_awvalid || m_awready;
  assign w_fin  = !m_wvalid || m_wready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      rr        <= CW'(NUM_CH - 1);
      g         <= '0;
      busy_q    <= '0;
      done_q    <= '0;
      err_q     <= '0;
      m_araddr  <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      m_awaddr  <= '0;
      m_awvalid <= 1'b0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
        rem_q[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (has_req) begin
            g         <= nxt;
            rr        <= nxt;
            m_araddr  <= src_q[nxt];
            m_arvalid <= 1'b1;
            state     <= RD_A;
          end
        end
        RD_A: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RD_D;
          end
        end
        RD_D: begin
          if (m_rvalid) begin
            m_rready <= 1'b0;
            if (m_rresp != 2'b00) begin
              err_q[g]  <= 1'b1;
              done_q[g] <= 1'b1;
              busy_q[g] <= 1'b0;
              state     <= IDLE;
            end else begin
              m_wdata   <= m_rdata;
              m_wstrb   <= '1;
              m_awaddr  <= dst_q[g];
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              state     <= WR;
            end
          end
        end
        WR: begin
          if (m_awvalid && m_awready) m_awvalid <= 1'b0;
          if (m_wvalid && m_wready) m_wvalid <= 1'b0;
          if (aw_fin && w_fin) begin
            m_bready <= 1'b1;
            state    <= WR_B;
          end
        end
        WR_B: begin
          if (m_bvalid) begin
            m_bready <= 1'b0;
            state    <= IDLE;
            if (m_bresp != 2'b00) begin
              err_q[g]  <= 1'b1;
              done_q[g] <= 1'b1;
              busy_q[g] <= 1'b0;
            end else begin
              src_q[g] <= src_q[g] + STEP;
              dst_q[g] <= dst_q[g] + STEP;
              rem_q[g] <= rem_q[g] - 1'b1;
              if (rem_q[g] == LEN_WIDTH'(1)) begin
                busy_q[g] <= 1'b0;
                done_q[g] <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
      // busy channels ignore start, so this never races the FSM
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_start[i] && !busy_q[i]) begin
          src_q[i]  <= ch_src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          dst_q[i]  <= ch_dst_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          rem_q[i]  <= ch_len[i*LEN_WIDTH +: LEN_WIDTH];
          err_q[i]  <= 1'b0;
          done_q[i] <= (ch_len[i*LEN_WIDTH +: LEN_WIDTH] == '0);
          busy_q[i] <= (ch_len[i*LEN_WIDTH +: LEN_WIDTH] != '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_mc_engine.sv
// Directed bench for dma_mc_engine with a small AXI-Lite memory model.
// Source data is a fixed function of address; writes land in mem.
module tb_dma_mc_engine;

  logic         clk = 1'b0;
  logic         rstn;
  logic [3:0]   ch_start;
  logic [127:0] ch_src_addr;
  logic [127:0] ch_dst_addr;
  logic [63:0]  ch_len;
  logic [3:0]   ch_busy, ch_done, ch_err;
  logic [31:0]  m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]   m_wstrb;
  logic         m_awvalid, m_awready, m_wvalid, m_wready;
  logic [1:0]   m_bresp, m_rresp;
  logic         m_bvalid, m_bready, m_arvalid, m_arready;
  logic         m_rvalid, m_rready;

  int checks = 0;
  int failures = 0;

  // slave model controls
  int          aw_delay = 0;
  logic        r_hold = 1'b0;
  logic        rerr_en = 1'b0;
  logic [31:0] rerr_addr = '0;
  logic        berr_en = 1'b0;
  logic [31:0] berr_addr = '0;

  dma_mc_engine dut (
    .clk(clk), .rstn(rstn), .ch_start(ch_start),
    .ch_src_addr(ch_src_addr), .ch_dst_addr(ch_dst_addr),
    .ch_len(ch_len), .ch_busy(ch_busy), .ch_done(ch_done),
    .ch_err(ch_err), .m_awaddr(m_awaddr),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready), .m_araddr(m_araddr),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] src_data(input logic [31:0] a);
    return 32'hA000_0000 ^ a;
  endfunction

  // memory model
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ar_log [$];
  int          aw_cnt = 0;
  logic        aw_got = 1'b0, w_got = 1'b0;
  logic [31:0] waddr_q = '0, wdat_q = '0;
  logic [31:0] wa, wd;
  int          wr_cnt = 0, b_cnt = 0, wv_cyc = 0;
  int          aw_stall = 0, aw_unstable = 0;
  logic        aw_prev_stall = 1'b0;
  logic [31:0] aw_prev_addr = '0;

  assign m_arready = 1'b1;
  assign m_wready  = 1'b1;
  assign m_awready = m_awvalid && (aw_cnt >= aw_delay);

  always @(posedge clk) begin
    if (!rstn) begin
      m_rvalid <= 1'b0;
      m_rdata  <= '0;
      m_rresp  <= '0;
      m_bvalid <= 1'b0;
      m_bresp  <= '0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      aw_cnt   <= 0;
    end else begin
      if (m_awvalid && !m_awready) aw_cnt <= aw_cnt + 1;
      else aw_cnt <= 0;
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
      if (m_arvalid && m_arready) begin
        ar_log.push_back(m_araddr);
        m_rdata <= src_data(m_araddr);
        m_rresp <= (rerr_en && m_araddr == rerr_addr) ? 2'd2 : 2'd0;
        if (!r_hold) m_rvalid <= 1'b1;
      end
      if (m_awvalid && m_awready) begin
        aw_got  <= 1'b1;
        waddr_q <= m_awaddr;
        wr_cnt  <= wr_cnt + 1;
      end
      if (m_wvalid && m_wready) begin
        w_got  <= 1'b1;
        wdat_q <= m_wdata;
      end
      if ((aw_got || (m_awvalid && m_awready)) &&
          (w_got || (m_wvalid && m_wready))) begin
        wa = (m_awvalid && m_awready) ? m_awaddr : waddr_q;
        wd = (m_wvalid && m_wready) ? m_wdata : wdat_q;
        mem[wa] = wd;
        m_bvalid <= 1'b1;
        m_bresp  <= (berr_en && wa == berr_addr) ? 2'd2 : 2'd0;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end
      if (m_bvalid && m_bready) begin
        m_bvalid <= 1'b0;
        b_cnt    <= b_cnt + 1;
      end
    end
    if (m_wvalid) wv_cyc <= wv_cyc + 1;
    if (m_awvalid && !m_awready) aw_stall <= aw_stall + 1;
    if (aw_prev_stall && m_awaddr != aw_prev_addr)
      aw_unstable <= aw_unstable + 1;
    aw_prev_stall <= m_awvalid && !m_awready;
    aw_prev_addr  <= m_awaddr;
  end

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic prog(input int ch, input logic [31:0] s,
                      input logic [31:0] d, input logic [15:0] l);
    ch_src_addr[ch*32 +: 32] = s;
    ch_dst_addr[ch*32 +: 32] = d;
    ch_len[ch*16 +: 16]      = l;
  endtask

  task automatic pulse(input logic [3:0] m);
    ch_start = m;
    @(negedge clk);
    ch_start = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (ch_busy != 4'h0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 64'(n < 400), 64'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  int ab, wb, bb, sb, vb;

  initial begin
    ch_start = '0;
    ch_src_addr = '0;
    ch_dst_addr = '0;
    ch_len = '0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", ch_busy, 0);
    chk("rst_done", ch_done, 0);
    chk("rst_err", ch_err, 0);
    chk("rst_valids", {m_arvalid, m_awvalid, m_wvalid,
                       m_rready, m_bready}, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_wstrb", m_wstrb, 0);
    rstn = 1'b1;
    @(negedge clk);

    // single channel, zero-wait
    ab = ar_log.size();
    prog(0, 32'h0, 32'h80, 16'd4);
    pulse(4'b0001);
    chk("s_busy_t1", ch_busy[0], 1);
    chk("s_arv_t1", m_arvalid, 0);
    @(negedge clk);
    chk("s_arv_t2", m_arvalid, 1);
    chk("s_araddr_t2", m_araddr, 32'h0);
    wait_idle("single");
    for (int i = 0; i < 4; i++)
      chk($sformatf("s_mem%0d", i), rd_mem(32'h80 + 32'(4 * i)),
          src_data(32'(4 * i)));
    chk("s_done", ch_done[0], 1);
    chk("s_busy", ch_busy[0], 0);
    chk("s_nar", ar_log.size() - ab, 4);

    // len=0
    wb = wr_cnt;
    ab = ar_log.size();
    prog(1, 32'h40, 32'h140, 16'd0);
    pulse(4'b0010);
    chk("z_done", ch_done[1], 1);
    chk("z_busy", ch_busy[1], 0);
    chk("z_arv", m_arvalid, 0);
    repeat (3) @(negedge clk);
    chk("z_nar", ar_log.size() - ab, 0);
    chk("z_nwr", wr_cnt - wb, 0);

    // interleave from a fresh round-robin pointer
    do_reset();
    chk("i_rst_done", ch_done, 0);
    ab = ar_log.size();
    prog(0, 32'h100, 32'h200, 16'd3);
    prog(2, 32'h300, 32'h400, 16'd2);
    pulse(4'b0101);
    begin
      int n = 0;
      while (!ch_done[2] && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("i_d2_timeout", 64'(n < 400), 64'd1);
    end
    chk("i_d0_late", ch_done[0], 0);
    wait_idle("ilv");
    chk("i_nar", ar_log.size() - ab, 5);
    chk("i_ar0", ar_log[ab], 32'h100);
    chk("i_ar1", ar_log[ab + 1], 32'h300);
    chk("i_ar2", ar_log[ab + 2], 32'h104);
    chk("i_ar3", ar_log[ab + 3], 32'h304);
    chk("i_ar4", ar_log[ab + 4], 32'h108);
    chk("i_mem0", rd_mem(32'h208), src_data(32'h108));
    chk("i_mem2", rd_mem(32'h404), src_data(32'h304));
    chk("i_done", ch_done, 4'b0101);

    // restart while busy is ignored
    ab = ar_log.size();
    wb = wr_cnt;
    prog(0, 32'h500, 32'h600, 16'd3);
    pulse(4'b0001);
    repeat (2) @(negedge clk);
    prog(0, 32'h700, 32'hE00, 16'd1);
    pulse(4'b0001);
    wait_idle("rst_busy_ign");
    chk("r_nar", ar_log.size() - ab, 3);
    chk("r_ar2", ar_log[ab + 2], 32'h508);
    chk("r_nwr", wr_cnt - wb, 3);
    chk("r_mem2", rd_mem(32'h608), src_data(32'h508));

    // source address wrap
    ab = ar_log.size();
    prog(1, 32'hFFFF_FFFC, 32'h800, 16'd2);
    pulse(4'b0010);
    wait_idle("wrap");
    chk("w_ar0", ar_log[ab], 32'hFFFF_FFFC);
    chk("w_ar1", ar_log[ab + 1], 32'h0);
    chk("w_mem1", rd_mem(32'h804), src_data(32'h0));

    // read error on second word of ch3
    wb = wr_cnt;
    rerr_en = 1'b1;
    rerr_addr = 32'h904;
    prog(3, 32'h900, 32'hA00, 16'd3);
    pulse(4'b1000);
    wait_idle("rerr");
    chk("re_err", ch_err[3], 1);
    chk("re_done", ch_done[3], 1);
    chk("re_nwr", wr_cnt - wb, 1);
    chk("re_mem", rd_mem(32'hA00), src_data(32'h900));
    rerr_en = 1'b0;
    prog(3, 32'h900, 32'hA80, 16'd1);
    pulse(4'b1000);
    chk("re_clr_err", ch_err[3], 0);
    chk("re_clr_done", ch_done[3], 0);
    chk("re_clr_busy", ch_busy[3], 1);
    wait_idle("rerr2");
    chk("re2_done", ch_done[3], 1);
    chk("re2_err", ch_err[3], 0);

    // write response error
    wb = wr_cnt;
    berr_en = 1'b1;
    berr_addr = 32'hB00;
    prog(2, 32'h100, 32'hB00, 16'd2);
    pulse(4'b0100);
    wait_idle("berr");
    chk("be_err", ch_err[2], 1);
    chk("be_done", ch_done[2], 1);
    chk("be_nwr", wr_cnt - wb, 1);
    berr_en = 1'b0;

    // awready backpressure
    aw_delay = 3;
    sb = aw_stall;
    vb = wv_cyc;
    bb = b_cnt;
    wb = aw_unstable;
    prog(0, 32'h10C, 32'hC00, 16'd1);
    pulse(4'b0001);
    wait_idle("bp");
    chk("bp_stall", aw_stall - sb, 3);
    chk("bp_wv", wv_cyc - vb, 1);
    chk("bp_b", b_cnt - bb, 1);
    chk("bp_stable", aw_unstable - wb, 0);
    chk("bp_mem", rd_mem(32'hC00), src_data(32'h10C));
    aw_delay = 0;

    // reset while waiting for read data
    r_hold = 1'b1;
    prog(0, 32'h100, 32'hD00, 16'd2);
    pulse(4'b0001);
    begin
      int n = 0;
      while (!m_rready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("mr_rd_timeout", 64'(n < 50), 64'd1);
    end
    rstn = 1'b0;
    @(negedge clk);
    chk("mr_valids", {m_arvalid, m_awvalid, m_wvalid,
                      m_rready, m_bready}, 0);
    chk("mr_busy", ch_busy, 0);
    chk("mr_done", ch_done, 0);
    chk("mr_err", ch_err, 0);
    rstn = 1'b1;
    r_hold = 1'b0;
    @(negedge clk);
    prog(0, 32'h200, 32'hD00, 16'd2);
    pulse(4'b0001);
    wait_idle("mr_fresh");
    chk("mr_done2", ch_done[0], 1);
    chk("mr_mem1", rd_mem(32'hD04), src_data(32'h204));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
